// File: rtl/rom_access_arbiter_pkg.sv
// rtl/rom_access_arbiter_pkg.sv - shared widths, requester ids and defaults for the ROM arbiter
package rom_access_arbiter_pkg;

    localparam int ROM_ADDR_W           = 16;
    localparam int ROM_DATA_W           = 28;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int STARVE_CNT_W         = 4;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/rom_arb_select.sv
// rtl/rom_arb_select.sv - winner select with starvation guard, or round-robin when ROM_ARB_ROUND_ROBIN_EN
module rom_arb_select
    import rom_access_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    req0_i,
    input  logic    req1_i,
    output logic    any_o,
    output req_id_e winner_o
);

    assign any_o = req0_i | req1_i;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    req_id_e last_q;

    always_comb begin
        winner_o = REQ_CORE;
        if (req0_i && req1_i) begin
            winner_o = (last_q == REQ_CORE) ? REQ_DBG : REQ_CORE;
        end else if (req1_i) begin
            winner_o = REQ_DBG;
        end
    end

    // Pointer starts at the debug port so the core takes the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_DBG;
        end else if (any_o) begin
            last_q <= winner_o;
        end
    end
`else
    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;

    always_comb begin
        winner_o = (req1_i && (!req0_i || starve_q == LIMIT_C)) ? REQ_DBG : REQ_CORE;
        starve_d = '0;
        // Only a debug request that loses to the core ages the counter.
        if (req1_i && winner_o == REQ_CORE) begin
            starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

endmodule

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - two-port ROM arbiter, address/owner pipeline and data capture; ROM_ARB_ROUND_ROBIN_EN selects round-robin
module rom_access_arbiter
    import rom_access_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iReq0,
    input  logic [ADDR_W-1:0] iAddr0,
    output logic              oGnt0,
    output logic              oValid0,
    output logic [DATA_W-1:0] oData0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr1,
    output logic              oGnt1,
    output logic              oValid1,
    output logic [DATA_W-1:0] oData1,
    output logic [ADDR_W-1:0] oRomAddress,
    input  logic [DATA_W-1:0] iRomInstruction
);

    logic    any_req;
    req_id_e winner;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    req_id_e           owner_q, owner_d;
    logic              owner_valid_q, owner_valid_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;

    rom_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .req0_i  (iReq0),
        .req1_i  (iReq1),
        .any_o   (any_req),
        .winner_o(winner)
    );

    // Stage 1: latch the winner's address and remember who owns the ROM read.
    always_comb begin
        rom_addr_d    = rom_addr_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        owner_d       = owner_q;
        owner_valid_d = 1'b0;
        if (any_req) begin
            rom_addr_d    = (winner == REQ_DBG) ? iAddr1 : iAddr0;
            gnt0_d        = (winner == REQ_CORE);
            gnt1_d        = (winner == REQ_DBG);
            owner_d       = winner;
            owner_valid_d = 1'b1;
        end
    end

    // Stage 2: the ROM answers combinationally; steer it to the owner.
    always_comb begin
        data0_d  = data0_q;
        data1_d  = data1_q;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        if (owner_valid_q) begin
            if (owner_q == REQ_DBG) begin
                data1_d  = iRomInstruction;
                valid1_d = 1'b1;
            end else begin
                data0_d  = iRomInstruction;
                valid0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rom_addr_q    <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            owner_q       <= REQ_CORE;
            owner_valid_q <= 1'b0;
            valid0_q      <= 1'b0;
            valid1_q      <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
        end else begin
            rom_addr_q    <= rom_addr_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            valid0_q      <= valid0_d;
            valid1_q      <= valid1_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
        end
    end

    assign oRomAddress = rom_addr_q;
    assign oGnt0       = gnt0_q;
    assign oGnt1       = gnt1_q;
    assign oValid0     = valid0_q;
    assign oValid1     = valid1_q;
    assign oData0      = data0_q;
    assign oData1      = data1_q;

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single combinational program ROM (16-bit address in, 28-bit instruction out) between two requesters.
- Requester 0 is the core instruction fetch; requester 1 is the debug/monitor read port.
- Registers the ROM address and captures the returned instruction into a per-requester data register.
- Pipelined: one grant per cycle. Fixed priority to requester 0, with a starvation guard for requester 1.

Parameters:
- ADDR_W, 16, ROM address width.
- DATA_W, 28, instruction width.
- STARVE_LIMIT, 4, consecutive lost cycles after which requester 1 wins. Legal range is 1..15.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iReq0  input  1  requester 0 read request.
- iAddr0  input  ADDR_W  requester 0 address.
- oGnt0  output  1  requester 0 address accepted.
- oValid0  output  1  oData0 updated this cycle.
- oData0  output  DATA_W  requester 0 instruction.
- iReq1, iAddr1, oGnt1, oValid1, oData1: same as requester 0, for requester 1.
- oRomAddress  output  ADDR_W  registered address to ROM.
- iRomInstruction  input  DATA_W  combinational ROM data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs 0; oRomAddress=0.
  - Starvation counter 0; in-flight owner cleared.
  - A read in flight when reset asserts is dropped: no oValid after release.
- Arbitration (combinational, on iReq0/iReq1 in cycle k):
  - Only one requesting: that one wins.
  - Both requesting: requester 1 wins if starve_cnt==STARVE_LIMIT, else requester 0 wins.
- Edge ending cycle k:
  - oRomAddress <= winner's address.
  - oGntW <= 1 and the other oGnt <= 0.
  - Owner register <= W, owner_valid <= 1.
  - No request: oGnt0=oGnt1=0, owner_valid <= 0, oRomAddress holds.
- Cycle k+1: oGntW=1 for exactly one cycle; the ROM presents iRomInstruction for oRomAddress.
- Edge ending cycle k+1: if owner_valid, oDataW <= iRomInstruction and oValidW <= 1, else both oValid <= 0.
- Latency: request in cycle k -> grant in cycle k+1 -> data and oValid in cycle k+2.
- Requester handshake:
  - Holds iReq/iAddr stable until it samples oGnt=1.
  - If iReq is still high in the oGnt cycle, it is a new back-to-back request, arbitrated normally.
- oDataX holds its last value until the next oValidX. oValidX is a single-cycle pulse per grant.
- Starvation counter (3-4 bits, saturating at STARVE_LIMIT):
  - Increments on every edge where iReq1=1 and requester 0 wins.
  - Clears when requester 1 is granted or iReq1=0.
- Throughput: with both requesters continuously requesting, requester 1 gets exactly one grant per STARVE_LIMIT+1 cycles.
- Addresses pass through unchecked. Out-of-range addresses return whatever the ROM default decode supplies.
- A change of iAddr while iReq is high and not yet granted is legal; the value sampled at the grant edge is used.

Optional Feature:
- ROM_ARB_ROUND_ROBIN_EN defined:
  - Replaces fixed priority with round-robin via a 1-bit last-winner pointer. On a tie, the requester that did not win last is granted.
  - Pointer resets to 1, so requester 0 wins the first tie.
  - Starvation counter and STARVE_LIMIT are unused.
- Undefined: fixed priority with starvation guard, as described under Behaviour.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared definitions header holds:
  - ROM address/data widths (16/28).
  - Requester index constants REQ_CORE=0 and REQ_DBG=1.
  - Default STARVE_LIMIT.
- One natural sub-module: rom_arb_select. It is the combinational winner select plus the starvation counter or round-robin pointer.
- The top level holds the address/owner pipeline registers and the data capture registers.

Test Plan:
- The bench ROM model returns {12'hABC, addr}.
- Reset: hold Reset=0 with iReq0=iReq1=1 and addresses 0x0005/0x0009 -> all oGnt/oValid=0, oRomAddress=0. Release -> oGnt0=1 one cycle later, oValid0=1 with oData0=28'hABC0005 two cycles later.
- Single requester 1: iReq1=1, iAddr1=0x000E for one cycle -> oGnt1 in cycle k+1, oRomAddress=0x000E, then oValid1=1 with oData1=28'hABC000E in cycle k+2. oData0 remains 0.
- Starvation (fixed priority, STARVE_LIMIT=4): both requesting continuously, addr0 incrementing from 0, addr1=0x0100 -> grant pattern 0,0,0,0,1 repeating. oData1=28'hABC0100 on every fifth oValid.
- Back-to-back: iReq0 high for 3 cycles with addresses 1,2,3 -> three consecutive oGnt0 pulses and three consecutive oValid0 carrying 0xABC0001, 0xABC0002, 0xABC0003.
- Reset mid-operation: assert Reset=0 in the grant cycle of requester 1 -> no oValid1 appears after release, and the starvation counter restarts at 0.
- ROM_ARB_ROUND_ROBIN_EN build: both requesting continuously -> grants alternate 0,1,0,1, each oValid carries the matching address data.
